// File: rtl/tqvp_spi_reg_master.sv
// SPI initiator for the TinyQV peripheral register protocol: one bus request becomes
// one CS-framed 8/16/32-bit register write or read (mode 0, MSB first).
module tqvp_spi_reg_master #(
    parameter int CLK_DIV         = 4,
    parameter int READ_DUMMY_BITS = 8,
    parameter int CS_GAP          = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rw,
    input  logic [5:0]  addr,
    input  logic [1:0]  txn_width,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        spi_cs_n,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    localparam int MAX_DIV = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(MAX_DIV + 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  div_cnt, div_last;
    logic              phase_end, last_bit, accept, fall_edge, rise_edge;
    logic [5:0]        bit_cnt, n_bits, n_bits_in;
    logic              rw_q;
    logic [1:0]        w_q, w_in;
    logic [47:0]       tx_sr, frame;
    logic [31:0]       rx_sr, wdata_al;

    // Request decode: width code 11 behaves as 32 bits, write data is MSB-aligned in the frame.
    always_comb begin
        w_in      = (txn_width == 2'b11) ? 2'b10 : txn_width;
        n_bits_in = 6'd16 + (rw ? 6'd0 : 6'(READ_DUMMY_BITS)) + (6'd8 << w_in);
        case (w_in)
            2'b00:   wdata_al = {wdata[7:0], 24'd0};
            2'b01:   wdata_al = {wdata[15:0], 16'd0};
            default: wdata_al = wdata;
        endcase
        frame = {rw, 5'b0, w_in, 2'b00, addr, (rw ? wdata_al : 32'd0)};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal driven here is given a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        div_last   = (state == S_GAP) ? CNT_W'(CS_GAP - 1) : CNT_W'(CLK_DIV - 1);
        phase_end  = (state != S_IDLE) && (div_cnt == div_last);
        last_bit   = (bit_cnt == n_bits);
        accept     = (state == S_IDLE) && start;
        fall_edge  = (state == S_SHIFT) && spi_clk && phase_end;
        rise_edge  = ((state == S_SETUP) && phase_end) ||
                     ((state == S_SHIFT) && !spi_clk && phase_end && !last_bit);
        case (state)
            S_IDLE:  if (start) state_next = S_SETUP;
            S_SETUP: if (phase_end) state_next = S_SHIFT;
            S_SHIFT: if (phase_end && !spi_clk && last_bit) state_next = S_HOLD;
            S_HOLD:  if (phase_end) state_next = S_GAP;
            S_GAP:   if (phase_end) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_GAP) && phase_end;

    // SPI pins are registered from the next state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            n_bits   <= '0;
            rw_q     <= 1'b0;
            w_q      <= 2'b00;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rdata    <= '0;
            spi_cs_n <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            div_cnt  <= ((state == S_IDLE) || phase_end) ? '0 : div_cnt + 1'b1;
            spi_cs_n <= !(state_next inside {S_SETUP, S_SHIFT, S_HOLD});
            if (rise_edge)            spi_clk <= 1'b1;
            else if (fall_edge)       spi_clk <= 1'b0;
            else if (state != S_SHIFT) spi_clk <= 1'b0;

            if (accept) begin
                rw_q     <= rw;
                w_q      <= w_in;
                n_bits   <= n_bits_in;
                bit_cnt  <= '0;
                tx_sr    <= {frame[46:0], 1'b0};
                spi_mosi <= frame[47];
            end else if (fall_edge) begin
                // miso is taken in the last cycle of the high phase, mosi advances on the fall
                bit_cnt  <= bit_cnt + 1'b1;
                tx_sr    <= {tx_sr[46:0], 1'b0};
                spi_mosi <= tx_sr[47];
                rx_sr    <= {rx_sr[30:0], spi_miso};
            end else if (state_next == S_HOLD) begin
                spi_mosi <= 1'b0;
            end

            if ((state == S_HOLD) && phase_end && !rw_q) begin
                case (w_q)
                    2'b00:   rdata <= {24'd0, rx_sr[7:0]};
                    2'b01:   rdata <= {16'd0, rx_sr[15:0]};
                    default: rdata <= rx_sr;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tqvp_spi_reg_master.sv
// Bench for tqvp_spi_reg_master: a behavioural SPI target on the pins plus a frame-level
// reference model of what each request must put on the wire and return.
module tb_tqvp_spi_reg_master;

    localparam int CLK_DIV = 4;
    localparam int RDB     = 8;
    localparam int CS_GAP  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic [5:0]  addr = '0;
    logic [1:0]  txn_width = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, spi_cs_n, spi_clk, spi_mosi;
    logic        spi_miso = 1'b0;
    logic [31:0] rdata;

    tqvp_spi_reg_master #(.CLK_DIV(CLK_DIV), .READ_DUMMY_BITS(RDB), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr),
        .txn_width(txn_width), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Target-side monitor state
    logic        cap [64];
    logic        miso_bits [64];
    int          rise_cnt = 0, fall_cnt = 0, mosi_viol = 0, done_cnt = 0;
    int          gap_run = 0, last_gap = 0;
    logic        sck_prev = 1'b0, cs_prev = 1'b1, mosi_prev = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] slave_regs [64];

    initial begin
        forever begin
            @(negedge clk);
            if (cs_prev && !spi_cs_n) begin
                last_gap = gap_run;
                rise_cnt = 0;
                fall_cnt = 0;
                spi_miso = miso_bits[0];
            end
            gap_run = spi_cs_n ? gap_run + 1 : 0;
            if (!sck_prev && spi_clk) begin
                if (rise_cnt < 64) cap[rise_cnt] = spi_mosi;
                rise_cnt++;
            end
            if (sck_prev && spi_clk && (spi_mosi !== mosi_prev)) mosi_viol++;
            if (sck_prev && !spi_clk) begin
                fall_cnt++;
                spi_miso = (fall_cnt < 64) ? miso_bits[fall_cnt] : 1'b0;
            end
            if (done) done_cnt++;
            sck_prev  = spi_clk;
            cs_prev   = spi_cs_n;
            mosi_prev = spi_mosi;
        end
    end

    function automatic logic [1:0] eff_w(input logic [1:0] tw);
        return (tw == 2'b11) ? 2'b10 : tw;
    endfunction

    function automatic int data_bits(input logic [1:0] tw);
        return 8 << eff_w(tw);
    endfunction

    function automatic int frame_bits(input bit is_wr, input logic [1:0] tw);
        return 16 + (is_wr ? 0 : RDB) + data_bits(tw);
    endfunction

    function automatic logic [31:0] pack_cap(input int first, input int count);
        logic [31:0] v = '0;
        for (int i = 0; i < count; i++) v = {v[30:0], cap[first + i]};
        return v;
    endfunction

    // One request from the cycle start is driven until the cycle after done; returns at a negedge.
    task automatic run_txn(input bit is_wr, input logic [5:0] a, input logic [1:0] tw,
                           input logic [31:0] wd, input logic [31:0] md, input int spur_at,
                           input string name);
        int nb, nt, pre, start_cyc, len, viol0, done0;
        bit seen;
        logic [31:0] mask;
        logic [15:0] exp_hdr;
        nb   = data_bits(tw);
        nt   = frame_bits(is_wr, tw);
        pre  = nt - nb;
        mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
        for (int k = 0; k < 64; k++) begin
            if (k < pre)     miso_bits[k] = 1'($urandom_range(0, 1));
            else if (k < nt) miso_bits[k] = md[nb - 1 - (k - pre)];
            else             miso_bits[k] = 1'b0;
        end
        rw = is_wr; addr = a; txn_width = tw; wdata = wd; start = 1'b1;
        start_cyc = cyc; viol0 = mosi_viol; done0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        rw = 1'($urandom); addr = 6'($urandom); txn_width = 2'($urandom); wdata = $urandom;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        seen = 1'b0;
        for (int t = 0; t < 1000 && !seen; t++) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                start = (t == spur_at);
                @(negedge clk);
            end
        end
        start = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL %s done_timeout: no done within 1000 cycles", name);
            return;
        end
        len = cyc - start_cyc + 1;
        n_checks++;
        if (len !== 1 + CLK_DIV * (2 + 2 * nt) + CS_GAP) begin
            n_fail++;
            $display("FAIL %s length: got %0d want %0d", name, len, 1 + CLK_DIV * (2 + 2 * nt) + CS_GAP);
        end
        n_checks++;
        if (rise_cnt !== nt) begin
            n_fail++; $display("FAIL %s sck_edges: got %0d want %0d", name, rise_cnt, nt);
        end
        exp_hdr = {is_wr, 5'b0, eff_w(tw), 2'b00, a};
        n_checks++;
        if (pack_cap(0, 16) !== {16'd0, exp_hdr}) begin
            n_fail++; $display("FAIL %s header: got %h want %h", name, pack_cap(0, 16), exp_hdr);
        end
        if (is_wr) begin
            n_checks++;
            if (pack_cap(16, nb) !== (wd & mask)) begin
                n_fail++; $display("FAIL %s wr_data: got %h want %h", name, pack_cap(16, nb), wd & mask);
            end
        end else begin
            n_checks++;
            if (pack_cap(16, RDB) !== 32'd0) begin
                n_fail++; $display("FAIL %s dummy_bits: got %h want 0", name, pack_cap(16, RDB));
            end
            exp_rdata = md & mask;
        end
        n_checks++;
        if (mosi_viol !== viol0) begin
            n_fail++; $display("FAIL %s mosi_stable: got %0d changes while sck high want 0", name, mosi_viol - viol0);
        end
        n_checks++;
        if (rdata !== exp_rdata) begin
            n_fail++; $display("FAIL %s rdata: got %h want %h", name, rdata, exp_rdata);
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy, spi_cs_n} !== 3'b001 || (done_cnt - done0) !== 1) begin
            n_fail++;
            $display("FAIL %s after_done: got done=%b busy=%b cs_n=%b pulses=%0d want 0,0,1,1",
                     name, done, busy, spi_cs_n, done_cnt - done0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, spi_cs_n, spi_clk, spi_mosi} !== 5'b00100 || rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_in: got busy=%b done=%b cs_n=%b sck=%b mosi=%b rdata=%h want 0,0,1,0,0,0",
                     busy, done, spi_cs_n, spi_clk, spi_mosi, rdata);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, spi_cs_n, spi_clk, spi_mosi} !== 5'b00100 || rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_out: got busy=%b done=%b cs_n=%b sck=%b mosi=%b rdata=%h want 0,0,1,0,0,0",
                     busy, done, spi_cs_n, spi_clk, spi_mosi, rdata);
        end
    endtask

    // Reset during the 10th data bit of a 32-bit read: idle levels at once, no done, rdata untouched.
    task automatic test_abort();
        logic [31:0] md;
        int done0;
        bit hit;
        md = $urandom | 32'h8000_0001;
        for (int k = 0; k < 64; k++) miso_bits[k] = 1'($urandom_range(0, 1));
        rw = 1'b0; addr = 6'h11; txn_width = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int t = 0; t < 1000 && !hit; t++) begin
            if (rise_cnt >= 16 + RDB + 10) hit = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!hit) begin
            n_fail++; $display("FAIL abort_reach_bit10: got %0d sck edges want %0d", rise_cnt, 16 + RDB + 10);
        end
        done0 = done_cnt;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({spi_cs_n, spi_clk, busy} !== 3'b100) begin
            n_fail++; $display("FAIL abort_idle: got cs_n=%b sck=%b busy=%b want 1,0,0", spi_cs_n, spi_clk, busy);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (done_cnt !== done0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - done0);
        end
        n_checks++;
        if (rdata !== exp_rdata) begin
            n_fail++; $display("FAIL abort_rdata: got %h want %h", rdata, exp_rdata);
        end
        md = md ^ 32'h1;
    endtask

    task automatic test_spec_vectors();
        run_txn(1'b1, 6'h05, 2'b00, 32'h0000_00A5, 32'h0, -1, "wr8");
        repeat (3) @(negedge clk);
        run_txn(1'b1, 6'h3F, 2'b10, 32'hDEAD_BEEF, 32'h0, -1, "wr32");
        repeat (3) @(negedge clk);
        run_txn(1'b0, 6'h02, 2'b01, 32'h0, 32'hFFFF_1234, -1, "rd16");
        n_checks++;
        if (rdata !== 32'h0000_1234) begin
            n_fail++; $display("FAIL rd16_value: got %h want 00001234", rdata);
        end
        repeat (3) @(negedge clk);
        run_txn(1'b0, 6'h00, 2'b11, 32'h0, 32'h89AB_CDEF, -1, "rd_w11");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_txn(1'($urandom), 6'($urandom), 2'($urandom), $urandom, $urandom,
                    (i % 3 == 0) ? int'($urandom_range(5, 60)) : -1, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 6'h2A, 2'b01, 32'h0000_5AC3, 32'h0, 20, "b2b_first");
        run_txn(1'b0, 6'h15, 2'b00, 32'h0, 32'h0000_00C9, -1, "b2b_second");
        n_checks++;
        if (last_gap < CS_GAP) begin
            n_fail++; $display("FAIL b2b_cs_gap: got %0d cycles want >= %0d", last_gap, CS_GAP);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_loopback();
        for (int i = 0; i < 64; i++) slave_regs[i] = '0;
        run_txn(1'b1, 6'h00, 2'b10, 32'hCAFE_F00D, 32'h0, -1, "loop_wr");
        if (cap[0]) slave_regs[pack_cap(10, 6)] = pack_cap(16, 32);
        repeat (3) @(negedge clk);
        run_txn(1'b0, 6'h00, 2'b10, 32'h0, slave_regs[0], -1, "loop_rd");
        n_checks++;
        if (rdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL loopback: got %h want cafef00d", rdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_abort();
        test_spec_vectors();
        test_random();
        test_back_to_back();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
